// File: rtl/fir_axis_out_fifo_if.sv
// AXI-Stream beat bundle used on both sides of fir_axis_out_fifo.
//   tdata  : sample, DATA_WIDTH bits
//   tvalid : beat valid
//   tlast  : last beat of a packet
//   tready : receiver ready
// Modports:
//   master : drives tdata/tvalid/tlast, observes tready
//   slave  : observes tdata/tvalid/tlast, drives tready
interface fir_axis_out_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fir_axis_out_fifo.sv
// Downstream AXI-Stream output buffer for the pipelined FIR filter.
// Every FIR beat {tlast, tdata} is captured into a circular first-word-
// fall-through FIFO and re-presented to the sink.
//
// Handshake: a beat moves across an interface on a rising edge where both
// tvalid and tready are 1. The sink side obeys this strictly. On the FIR
// side, s_axis.tready is only an almost-full hint: the FIR may keep sending
// after it falls, and a beat is taken whenever the FIFO has room (or frees a
// slot in the same cycle); beats arriving while full and not popping are
// dropped and flagged.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   s_axis       : slave side from the FIR (tready = almost-full backpressure)
//   m_axis       : master side to the sink
//   level        : occupancy 0..DEPTH
//   overflow     : sticky, a beat was dropped while full
//   overflow_clr : clears overflow (a same-cycle drop wins)
//   drop_cnt     : only with FIR_OUT_FIFO_DROP_CNT_EN defined; saturating
//                  16-bit count of dropped beats, cleared by overflow_clr
//
// Build option: define FIR_OUT_FIFO_DROP_CNT_EN to add the drop_cnt counter.
module fir_axis_out_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  fir_axis_out_fifo_if.slave         s_axis,
  fir_axis_out_fifo_if.master        m_axis,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       overflow_clr
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DATA_WIDTH:0]   head;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == PW'(DEPTH));
  assign empty = (level == '0);

  assign pop  = !empty && m_axis.tready;
  // A pop in the same cycle frees the slot the write needs, so a full FIFO
  // still accepts the beat in that case.
  assign push = s_axis.tvalid && (!full || pop);
  assign drop = s_axis.tvalid && full && !pop;

  assign s_axis.tready = (level < PW'(DEPTH - AFULL_MARGIN));

  assign head          = mem[rd_ptr[AW-1:0]];
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
  assign m_axis.tlast  = empty ? 1'b0 : head[DATA_WIDTH];

  // Storage is not reset; contents are only visible behind valid pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Drop takes priority over clear so a drop is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef FIR_OUT_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (overflow_clr) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_axis_out_fifo.sv
module tb_fir_axis_out_fifo;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic overflow_clr;
  logic overflow;
  logic [4:0] level;
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  fir_axis_out_fifo_if #(.DATA_WIDTH(DW)) s_if ();
  fir_axis_out_fifo_if #(.DATA_WIDTH(DW)) m_if ();

  fir_axis_out_fifo #(.DATA_WIDTH(DW), .DEPTH(16), .AFULL_MARGIN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [DW:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one edge; record it as expected if it will be taken.
  task automatic send(input logic [DW-1:0] d, input logic last, input bit accepted);
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    if (accepted) exp_q.push_back({last, d});
    tick();
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_beat  = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {15'd0, m_if.tlast, m_if.tdata}, {15'd0, prev_beat});
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {15'd0, m_if.tlast, m_if.tdata}, 32'hFFFF_FFFF);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("beat", {15'd0, m_if.tlast, m_if.tdata}, {15'd0, e});
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = {m_if.tlast, m_if.tdata};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b1;
    overflow_clr = 1'b0;
    m_if.tready  = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset then idle
    check("rst_m_tvalid", {31'd0, m_if.tvalid}, 0);
    check("rst_m_tdata",  {16'd0, m_if.tdata}, 0);
    check("rst_m_tlast",  {31'd0, m_if.tlast}, 0);
    check("rst_s_tready", {31'd0, s_if.tready}, 1);
    check("rst_level",    {27'd0, level}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);

    // Pass-through 1,2,3 with tlast on 3, one-cycle latency
    m_if.tready = 1'b1;
    send(16'd1, 1'b0, 1'b1);
    check("lat_data1", {16'd0, m_if.tdata}, 1);
    check("lat_valid1", {31'd0, m_if.tvalid}, 1);
    send(16'd2, 1'b0, 1'b1);
    check("lat_data2", {16'd0, m_if.tdata}, 2);
    check("lat_last2", {31'd0, m_if.tlast}, 0);
    send(16'd3, 1'b1, 1'b1);
    check("lat_data3", {16'd0, m_if.tdata}, 3);
    check("lat_last3", {31'd0, m_if.tlast}, 1);
    idle();
    tick();
    check("pt_empty_valid", {31'd0, m_if.tvalid}, 0);
    check("pt_empty_level", {27'd0, level}, 0);

    // Fill to 14 with the sink stalled; s_tready falls at level 12
    m_if.tready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      send(16'h0100 + 16'(i), 1'b0, 1'b1);
      check("fill_level", {27'd0, level}, 32'(i + 1));
      check("fill_s_tready", {31'd0, s_if.tready}, (i + 1 < 12) ? 32'd1 : 32'd0);
    end
    check("fill_overflow", {31'd0, overflow}, 0);

    // Up to 16, then two drops
    send(16'h010E, 1'b0, 1'b1);
    send(16'h010F, 1'b1, 1'b1);
    check("full_level", {27'd0, level}, 16);
    send(16'hDEAD, 1'b0, 1'b0);
    send(16'hBEEF, 1'b1, 1'b0);
    idle();
    check("drop_level", {27'd0, level}, 16);
    check("drop_overflow", {31'd0, overflow}, 1);
    check("drop_head", {16'd0, m_if.tdata}, 32'h0100);
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
    check("drop_cnt2", {16'd0, drop_cnt}, 2);
`endif

    // Full FIFO streaming across pointer wrap: push and pop every cycle
    m_if.tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(16'h2000 + 16'(i), (i % 8 == 7), 1'b1);
      check("stream_level", {27'd0, level}, 16);
    end
    idle();
    check("stream_overflow", {31'd0, overflow}, 1);
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
    check("stream_drop_cnt", {16'd0, drop_cnt}, 2);
`endif

    // Clear, then clear coinciding with a drop
    m_if.tready  = 1'b0;
    overflow_clr = 1'b1;
    tick();
    check("clr_overflow", {31'd0, overflow}, 0);
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
    check("clr_drop_cnt", {16'd0, drop_cnt}, 0);
`endif
    send(16'h5555, 1'b0, 1'b0);
    idle();
    overflow_clr = 1'b0;
    check("clr_drop_overflow", {31'd0, overflow}, 1);
    check("clr_drop_level", {27'd0, level}, 16);
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
    check("clr_drop_cnt1", {16'd0, drop_cnt}, 1);
`endif

    // Drain the remaining 16
    m_if.tready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("drain_level", {27'd0, level}, 0);
    check("drain_valid", {31'd0, m_if.tvalid}, 0);

    // Reset with 5 beats buffered
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h0A00 + 16'(i), 1'b0, 1'b1);
    idle();
    check("pre_rst_level", {27'd0, level}, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_level", {27'd0, level}, 0);
    check("mid_rst_valid", {31'd0, m_if.tvalid}, 0);
    check("mid_rst_tdata", {16'd0, m_if.tdata}, 0);
    check("mid_rst_s_tready", {31'd0, s_if.tready}, 1);
    send(16'h7FFF, 1'b1, 1'b1);
    idle();
    check("post_rst_data", {16'd0, m_if.tdata}, 32'h7FFF);
    check("post_rst_last", {31'd0, m_if.tlast}, 1);
    m_if.tready = 1'b1;
    tick();
    check("post_rst_level", {27'd0, level}, 0);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
